// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU and the
// read-only display requester. The CPU has priority. A display request that
// has been denied MAX_WAIT consecutive times is forced through, and the CPU is
// stalled for that one cycle.
//
// owner_q state | meaning
// --------------+---------------------------------------------------------
// OWN_NONE      | no read issued last cycle (idle, store, or reset)
// OWN_CPU       | CPU load issued last cycle; ram_dataOut is the CPU's data
// OWN_VGA       | display read issued last cycle; vga_valid pulses now
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wEn,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_dataIn,
    output logic [DATA_W-1:0] cpu_dataOut,
    output logic              cpu_stall,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_data,
    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    owner_t     owner_q;
    logic       force_slot;
    logic       vga_sel;
    logic       cpu_sel;

    // Grant decision; reset blocks both grants so nothing reaches the RAM.
    always_comb begin
        force_slot = vga_req & (wait_cnt == WAIT_LIMIT);
        vga_sel    = ~reset & vga_req & (~cpu_req | force_slot);
        cpu_sel    = ~reset & cpu_req & ~vga_sel;
    end

    // RAM drive and handshake outputs; the display path never writes, so a
    // store losing to a forced slot is simply stalled and retried.
    always_comb begin
        ram_addr    = vga_sel ? vga_addr : cpu_addr;
        ram_wEn     = cpu_sel & cpu_wEn;
        ram_dataIn  = cpu_dataIn;
        cpu_stall   = cpu_req & vga_sel;
        vga_gnt     = vga_sel;
        cpu_dataOut = ram_dataOut;
        vga_data    = ram_dataOut;
        // Gated by reset so a read pending when reset hits never pulses.
        vga_valid   = ~reset & (owner_q == OWN_VGA);
    end

    // Starvation counter and return-path owner tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= 4'd0;
            owner_q  <= OWN_NONE;
        end else begin
            if (vga_sel || !vga_req) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            if (vga_sel) begin
                owner_q <= OWN_VGA;
            end else if (cpu_sel && !cpu_wEn) begin
                owner_q <= OWN_CPU;
            end else begin
                owner_q <= OWN_NONE;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous-read RAM.
module tb_dmem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              cpu_req;
    logic              cpu_wEn;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_dataIn;
    logic [DATA_W-1:0] cpu_dataOut;
    logic              cpu_stall;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_valid;
    logic [DATA_W-1:0] vga_data;
    logic              ram_wEn;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dataIn;
    logic [DATA_W-1:0] ram_dataOut;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_wEn(cpu_wEn), .cpu_addr(cpu_addr),
        .cpu_dataIn(cpu_dataIn), .cpu_dataOut(cpu_dataOut), .cpu_stall(cpu_stall),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_valid(vga_valid), .vga_data(vga_data),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
        .ram_dataOut(ram_dataOut)
    );

    // Single-port RAM, 1-cycle synchronous read.
    always @(posedge clock) begin
        if (ram_wEn) mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= mem[ram_addr];
    end

    typedef struct packed {
        logic              cpu_req;
        logic              cpu_wEn;
        logic [ADDR_W-1:0] cpu_addr;
        logic [DATA_W-1:0] cpu_dataIn;
        logic              vga_req;
        logic [ADDR_W-1:0] vga_addr;
        logic              e_gnt;
        logic              e_stall;
        logic              e_wen;
        logic              e_valid;
        logic [ADDR_W-1:0] e_addr;
    } vec_t;

    vec_t vecs [0:6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                         input logic [DATA_W-1:0] cd, input logic vr,
                         input logic [ADDR_W-1:0] va);
        cpu_req = cr; cpu_wEn = cw; cpu_addr = ca; cpu_dataIn = cd;
        vga_req = vr; vga_addr = va;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[12'h020] = 32'h1234_5678;
        mem[12'h021] = 32'h0BAD_CAFE;

        // Reset cycle with all requests active: nothing may be granted.
        reset = 1'b1;
        drive(1'b1, 1'b1, 12'h001, 32'h1111_1111, 1'b1, 12'h002);
        settle();
        chk("rst_gnt", 32'(vga_gnt), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_wen", 32'(ram_wEn), 32'd0);
        chk("rst_valid", 32'(vga_valid), 32'd0);
        adv();
        reset = 1'b0;

        // Consecutive single-cycle vectors starting from wait_cnt = 0.
        vecs[0] = '{1'b0, 1'b0, 12'h005, 32'h0,           1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h005};
        vecs[1] = '{1'b1, 1'b1, 12'h012, 32'hCAFE_F00D,   1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h012};
        vecs[2] = '{1'b1, 1'b0, 12'h012, 32'h0,           1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h012};
        vecs[3] = '{1'b0, 1'b0, 12'h007, 32'h0,           1'b1, 12'h020, 1'b1, 1'b0, 1'b0, 1'b0, 12'h020};
        vecs[4] = '{1'b1, 1'b0, 12'h011, 32'h0,           1'b1, 12'h021, 1'b0, 1'b0, 1'b0, 1'b1, 12'h011};
        vecs[5] = '{1'b0, 1'b0, 12'h011, 32'h0,           1'b1, 12'h021, 1'b1, 1'b0, 1'b0, 1'b0, 12'h021};
        vecs[6] = '{1'b1, 1'b1, 12'h040, 32'h0000_0001,   1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h040};
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].cpu_req, vecs[i].cpu_wEn, vecs[i].cpu_addr, vecs[i].cpu_dataIn,
                  vecs[i].vga_req, vecs[i].vga_addr);
            settle();
            chk($sformatf("vec%0d_gnt", i), 32'(vga_gnt), 32'(vecs[i].e_gnt));
            chk($sformatf("vec%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_wen", i), 32'(ram_wEn), 32'(vecs[i].e_wen));
            chk($sformatf("vec%0d_valid", i), 32'(vga_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
            adv();
        end

        // CPU only: store then load 0x010.
        drive(1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF, 1'b0, 12'h000);
        settle();
        chk("cpu_st_wen", 32'(ram_wEn), 32'd1);
        chk("cpu_st_stall", 32'(cpu_stall), 32'd0);
        adv();
        drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 12'h000);
        settle();
        chk("cpu_ld_wen", 32'(ram_wEn), 32'd0);
        chk("cpu_ld_stall", 32'(cpu_stall), 32'd0);
        adv();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
        settle();
        chk("cpu_ld_data", cpu_dataOut, 32'hDEAD_BEEF);
        chk("cpu_ld_novalid", 32'(vga_valid), 32'd0);
        adv();

        // Display only: read 0x020, single vga_valid pulse.
        drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 12'h020);
        settle();
        chk("vga_only_gnt", 32'(vga_gnt), 32'd1);
        adv();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
        settle();
        chk("vga_only_valid", 32'(vga_valid), 32'd1);
        chk("vga_only_data", vga_data, 32'h1234_5678);
        adv();
        settle();
        chk("vga_only_pulse", 32'(vga_valid), 32'd0);
        adv();

        // Contention: CPU load held, display waits 4 denied cycles then forced.
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 12'h050, 32'h0, 1'b1, 12'h060);
            settle();
            chk($sformatf("cont_c%0d_gnt", c), 32'(vga_gnt), 32'd0);
            chk($sformatf("cont_c%0d_stall", c), 32'(cpu_stall), 32'd0);
            adv();
        end
        settle();
        chk("cont_c4_gnt", 32'(vga_gnt), 32'd1);
        chk("cont_c4_stall", 32'(cpu_stall), 32'd1);
        chk("cont_c4_addr", 32'(ram_addr), 32'h060);
        adv();
        drive(1'b1, 1'b0, 12'h050, 32'h0, 1'b0, 12'h000);
        settle();
        chk("cont_c5_valid", 32'(vga_valid), 32'd1);
        chk("cont_c5_stall", 32'(cpu_stall), 32'd0);
        chk("cont_c5_addr", 32'(ram_addr), 32'h050);
        adv();

        // Forced slot collides with a CPU store; store retried next cycle.
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 12'h031, 32'h0, 1'b1, 12'h061);
            settle();
            chk($sformatf("fst_c%0d_gnt", c), 32'(vga_gnt), 32'd0);
            adv();
        end
        drive(1'b1, 1'b1, 12'h030, 32'hA5A5_A5A5, 1'b1, 12'h061);
        settle();
        chk("fst_force_gnt", 32'(vga_gnt), 32'd1);
        chk("fst_force_wen", 32'(ram_wEn), 32'd0);
        chk("fst_force_stall", 32'(cpu_stall), 32'd1);
        adv();
        drive(1'b1, 1'b1, 12'h030, 32'hA5A5_A5A5, 1'b0, 12'h000);
        settle();
        chk("fst_retry_wen", 32'(ram_wEn), 32'd1);
        chk("fst_retry_addr", 32'(ram_addr), 32'h030);
        chk("fst_retry_stall", 32'(cpu_stall), 32'd0);
        adv();
        drive(1'b1, 1'b0, 12'h030, 32'h0, 1'b0, 12'h000);
        adv();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
        settle();
        chk("fst_readback", cpu_dataOut, 32'hA5A5_A5A5);
        adv();

        // Alternating CPU requests with display held: display wins each idle cycle.
        for (int k = 0; k < 8; k++) begin
            drive(((k % 2) == 0), 1'b0, 12'h070, 32'h0, 1'b1, 12'(12'h100 + (k / 2)));
            settle();
            chk($sformatf("alt_k%0d_gnt", k), 32'(vga_gnt), 32'((k % 2) == 1));
            chk($sformatf("alt_k%0d_stall", k), 32'(cpu_stall), 32'd0);
            adv();
        end
        drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
        adv();

        // Reset mid-transfer: display granted at t, reset at t+1.
        drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 12'h021);
        settle();
        chk("rmt_t_gnt", 32'(vga_gnt), 32'd1);
        adv();
        reset = 1'b1;
        drive(1'b1, 1'b1, 12'h022, 32'h5555_5555, 1'b1, 12'h021);
        settle();
        chk("rmt_t1_valid", 32'(vga_valid), 32'd0);
        chk("rmt_t1_gnt", 32'(vga_gnt), 32'd0);
        chk("rmt_t1_wen", 32'(ram_wEn), 32'd0);
        chk("rmt_t1_stall", 32'(cpu_stall), 32'd0);
        adv();
        reset = 1'b0;
        drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
        settle();
        chk("rmt_t2_valid", 32'(vga_valid), 32'd0);
        adv();
        // Counter cleared by reset: a fresh contended request is denied.
        drive(1'b1, 1'b0, 12'h000, 32'h0, 1'b1, 12'h021);
        settle();
        chk("rmt_wait_clear", 32'(vga_gnt), 32'd0);
        adv();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
